// File: rtl/redirect_ctrl_if.sv
// Redirect controller port bundle: EX branch outcomes, exception redirect, IFU redirect
// handshake and predictor-update stream.
interface redirect_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              ex0_valid;
  logic              ex0_is_jmp;
  logic              ex0_flush_req;
  logic              ex0_act_taken;
  logic [ADDR_W-1:0] ex0_act_target;
  logic [ADDR_W-1:0] ex0_pc;
  logic              ex1_valid;
  logic              ex1_is_jmp;
  logic              ex1_flush_req;
  logic              ex1_act_taken;
  logic [ADDR_W-1:0] ex1_act_target;
  logic [ADDR_W-1:0] ex1_pc;
  logic              exc_valid;
  logic [ADDR_W-1:0] exc_target;
  logic              ifu_redir_ready;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              flush_front;
  logic              flush_ex1;
  logic              ex_stall;
  logic              bp_upd_valid;
  logic              bp_upd_ready;
  logic [ADDR_W-1:0] bp_upd_pc;
  logic [ADDR_W-1:0] bp_upd_target;
  logic              bp_upd_taken;

  modport slave (
    input  ex0_valid, ex0_is_jmp, ex0_flush_req, ex0_act_taken, ex0_act_target, ex0_pc,
    input  ex1_valid, ex1_is_jmp, ex1_flush_req, ex1_act_taken, ex1_act_target, ex1_pc,
    input  exc_valid, exc_target, ifu_redir_ready, bp_upd_ready,
    output redir_valid, redir_pc, flush_front, flush_ex1, ex_stall,
    output bp_upd_valid, bp_upd_pc, bp_upd_target, bp_upd_taken
  );

  modport master (
    output ex0_valid, ex0_is_jmp, ex0_flush_req, ex0_act_taken, ex0_act_target, ex0_pc,
    output ex1_valid, ex1_is_jmp, ex1_flush_req, ex1_act_taken, ex1_act_target, ex1_pc,
    output exc_valid, exc_target, ifu_redir_ready, bp_upd_ready,
    input  redir_valid, redir_pc, flush_front, flush_ex1, ex_stall,
    input  bp_upd_valid, bp_upd_pc, bp_upd_target, bp_upd_taken
  );
endinterface

// File: rtl/redirect_ctrl.sv
// Front-end redirect arbiter (exc > slot0 > slot1) with 1-cycle redirect latency, held until IFU ready;
// predictor updates queued in a dual-push FIFO; EX stalls while a redirect is held or FIFO has < 2 free slots.
module redirect_ctrl #(
  parameter int UPD_DEPTH = 4,
  parameter int ADDR_W    = 32
) (
  input logic            clk,
  input logic            rst_n,
  redirect_ctrl_if.slave ctrl_io
);

  localparam int PW = $clog2(UPD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, HOLD} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [ADDR_W-1:0] target;
  } upd_rec_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
  upd_rec_t          mem_q [UPD_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wa1;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              stall, live, m0, m1, sel_exc, sel_any;
  logic              push0, push1, pop;
  logic [ADDR_W-1:0] tgt0, tgt1, sel_tgt;
  upd_rec_t          rec0, rec1;

  // Stall uses the registered count only, so a same-cycle pop never releases EX early.
  assign stall   = rst_n & ((state_q == HOLD) | (cnt_q > CW'(UPD_DEPTH - 2)));
  assign live    = rst_n & ~stall;
  assign m0      = live & ctrl_io.ex0_valid & ctrl_io.ex0_is_jmp & ctrl_io.ex0_flush_req;
  assign m1      = live & ctrl_io.ex1_valid & ctrl_io.ex1_is_jmp & ctrl_io.ex1_flush_req & ~m0;
  assign sel_exc = rst_n & ctrl_io.exc_valid;
  assign sel_any = sel_exc | m0 | m1;

  // Not-taken fall-through skips the delay slot.
  assign tgt0 = ctrl_io.ex0_act_taken ? ctrl_io.ex0_act_target : ctrl_io.ex0_pc + ADDR_W'(8);
  assign tgt1 = ctrl_io.ex1_act_taken ? ctrl_io.ex1_act_target : ctrl_io.ex1_pc + ADDR_W'(8);

  always_comb begin
    sel_tgt = tgt1;
    if (sel_exc) begin
      sel_tgt = ctrl_io.exc_target;
    end else if (m0) begin
      sel_tgt = tgt0;
    end
  end

  assign ctrl_io.flush_front = sel_any;
  assign ctrl_io.flush_ex1   = sel_exc | m0;
  assign ctrl_io.ex_stall    = stall;

  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    if (sel_any) begin
      state_d    = HOLD;
      redir_pc_d = sel_tgt;
    end else if ((state_q == HOLD) && ctrl_io.ifu_redir_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign ctrl_io.redir_valid = (state_q == HOLD);
  assign ctrl_io.redir_pc    = redir_pc_q;

  // An exception kills both slots; a slot-0 mispredict kills slot 1.
  assign push0 = live & ctrl_io.ex0_valid & ctrl_io.ex0_is_jmp & ~sel_exc;
  assign push1 = live & ctrl_io.ex1_valid & ctrl_io.ex1_is_jmp & ~m0 & ~sel_exc;
  assign pop   = (cnt_q != '0) & ctrl_io.bp_upd_ready;

  assign rec0 = '{pc: ctrl_io.ex0_pc, taken: ctrl_io.ex0_act_taken, target: ctrl_io.ex0_act_target};
  assign rec1 = '{pc: ctrl_io.ex1_pc, taken: ctrl_io.ex1_act_taken, target: ctrl_io.ex1_act_target};
  assign wa1  = push0 ? wr_ptr_q + PW'(1) : wr_ptr_q;

  assign wr_ptr_d = wr_ptr_q + PW'(push0) + PW'(push1);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign cnt_d    = cnt_q + CW'(push0) + CW'(push1) - CW'(pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0) begin
      mem_q[wr_ptr_q] <= rec0;
    end
    if (push1) begin
      mem_q[wa1] <= rec1;
    end
  end

  assign ctrl_io.bp_upd_valid  = (cnt_q != '0);
  assign ctrl_io.bp_upd_pc     = mem_q[rd_ptr_q].pc;
  assign ctrl_io.bp_upd_taken  = mem_q[rd_ptr_q].taken;
  assign ctrl_io.bp_upd_target = mem_q[rd_ptr_q].target;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboarded bench for redirect_ctrl: directed scenarios followed by random traffic.
module tb_redirect_ctrl;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  redirect_ctrl_if #(.ADDR_W(AW)) bus ();

  redirect_ctrl #(.UPD_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctrl_io(bus)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          taken;
    logic [AW-1:0] tgt;
  } rec_t;

  logic [AW-1:0] redir_exp_q[$];
  rec_t          upd_exp_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    bus.ex0_valid = 0; bus.ex0_is_jmp = 0; bus.ex0_flush_req = 0; bus.ex0_act_taken = 0;
    bus.ex0_act_target = '0; bus.ex0_pc = '0;
    bus.ex1_valid = 0; bus.ex1_is_jmp = 0; bus.ex1_flush_req = 0; bus.ex1_act_taken = 0;
    bus.ex1_act_target = '0; bus.ex1_pc = '0;
    bus.exc_valid = 0; bus.exc_target = '0;
  endtask

  task automatic slot(int s, bit v, bit j, bit f, bit t, logic [AW-1:0] pc, logic [AW-1:0] tg);
    if (s == 0) begin
      bus.ex0_valid = v; bus.ex0_is_jmp = j; bus.ex0_flush_req = f;
      bus.ex0_act_taken = t; bus.ex0_pc = pc; bus.ex0_act_target = tg;
    end else begin
      bus.ex1_valid = v; bus.ex1_is_jmp = j; bus.ex1_flush_req = f;
      bus.ex1_act_taken = t; bus.ex1_pc = pc; bus.ex1_act_target = tg;
    end
  endtask

  // Reference model: evaluated shortly after inputs settle, then waits for the next negedge.
  task automatic tick();
    bit busy, stall, live, m0, m1, sel;
    logic [AW-1:0] tgt;
    #1;
    busy = (redir_exp_q.size() != 0);
    chk("redir_valid", 72'(bus.redir_valid), 72'(busy));
    if (busy) chk("redir_pc_held", 72'(bus.redir_pc), 72'(redir_exp_q[0]));
    chk("bp_upd_valid", 72'(bus.bp_upd_valid), 72'(upd_exp_q.size() != 0));
    if (!rst_n) begin
      chk("rst_flush_front", 72'(bus.flush_front), 72'(0));
      chk("rst_flush_ex1", 72'(bus.flush_ex1), 72'(0));
      chk("rst_ex_stall", 72'(bus.ex_stall), 72'(0));
      redir_exp_q.delete();
      upd_exp_q.delete();
    end else begin
      stall = busy || ((DEPTH - upd_exp_q.size()) < 2);
      live  = !stall;
      m0 = live && bus.ex0_valid && bus.ex0_is_jmp && bus.ex0_flush_req;
      m1 = live && bus.ex1_valid && bus.ex1_is_jmp && bus.ex1_flush_req && !m0;
      sel = bus.exc_valid || m0 || m1;
      chk("ex_stall", 72'(bus.ex_stall), 72'(stall));
      chk("flush_front", 72'(bus.flush_front), 72'(sel));
      chk("flush_ex1", 72'(bus.flush_ex1), 72'(bus.exc_valid || m0));
      if (bus.exc_valid) tgt = bus.exc_target;
      else if (m0) tgt = bus.ex0_act_taken ? bus.ex0_act_target : bus.ex0_pc + 32'd8;
      else tgt = bus.ex1_act_taken ? bus.ex1_act_target : bus.ex1_pc + 32'd8;
      if (sel) begin
        if (busy && !bus.ifu_redir_ready) redir_exp_q[0] = tgt;
        else redir_exp_q.push_back(tgt);
      end
      if (live && !bus.exc_valid) begin
        if (bus.ex0_valid && bus.ex0_is_jmp)
          upd_exp_q.push_back('{pc: bus.ex0_pc, taken: bus.ex0_act_taken, tgt: bus.ex0_act_target});
        if (bus.ex1_valid && bus.ex1_is_jmp && !m0)
          upd_exp_q.push_back('{pc: bus.ex1_pc, taken: bus.ex1_act_taken, tgt: bus.ex1_act_target});
      end
    end
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboards whenever the DUT completes a handshake.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && bus.redir_valid && bus.ifu_redir_ready) begin
        if (redir_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL redir_unexpected got=%0h want=none", bus.redir_pc);
        end else begin
          chk("redir_xfer", 72'(bus.redir_pc), 72'(redir_exp_q.pop_front()));
        end
      end
      if (rst_n && bus.bp_upd_valid && bus.bp_upd_ready) begin
        if (upd_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL upd_unexpected got=%0h want=none", bus.bp_upd_pc);
        end else begin
          r = upd_exp_q.pop_front();
          chk("upd_rec", {7'd0, bus.bp_upd_pc, bus.bp_upd_taken, bus.bp_upd_target}, 72'(r));
        end
      end
    end
  end

  initial begin
    clear_in();
    bus.ifu_redir_ready = 1; bus.bp_upd_ready = 1;
    @(negedge clk);
    tick(); tick();
    rst_n = 1;

    // Taken mispredict in slot 0.
    slot(0, 1, 1, 1, 1, 32'h1000, 32'h2000);
    tick();
    clear_in();
    chk("s1_redir_pc", 72'(bus.redir_pc), 72'(32'h2000));
    tick(); tick();

    // Not-taken slot-1 mispredict at the top of the address space.
    slot(0, 1, 1, 0, 0, 32'h0000_0100, 32'h0000_0500);
    slot(1, 1, 1, 1, 0, 32'hFFFF_FFFC, 32'h0000_0700);
    tick();
    clear_in();
    chk("s2_wrap_pc", 72'(bus.redir_pc), 72'(32'h4));
    tick(); tick();

    // Exception beats a simultaneous slot-0 mispredict.
    slot(0, 1, 1, 1, 1, 32'h3000, 32'h4000);
    bus.exc_valid = 1; bus.exc_target = 32'hBFC0_0380;
    tick();
    clear_in();
    chk("s3_exc_pc", 72'(bus.redir_pc), 72'(32'hBFC0_0380));
    tick(); tick();

    // IFU back-pressure, then an exception replaces the held redirect.
    bus.ifu_redir_ready = 0;
    slot(0, 1, 1, 1, 1, 32'h5000, 32'h6000);
    tick();
    clear_in();
    tick(); tick(); tick();
    bus.exc_valid = 1; bus.exc_target = 32'h8000_0180;
    tick();
    clear_in();
    chk("s5_exc_replace", 72'(bus.redir_pc), 72'(32'h8000_0180));
    bus.ifu_redir_ready = 1;
    tick(); tick();

    // Fill the update FIFO, then drain it.
    bus.bp_upd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      slot(0, 1, 1, 0, i[0], 32'h100 + 32'(16 * i), 32'hA00 + 32'(i));
      slot(1, 1, 1, 0, 1, 32'h104 + 32'(16 * i), 32'hB00 + 32'(i));
      tick();
    end
    clear_in();
    chk("s6_full_stall", 72'(bus.ex_stall), 72'(1));
    tick();
    bus.bp_upd_ready = 1;
    for (int i = 0; i < 6; i++) tick();

    // Reset while holding a redirect with three records queued.
    bus.bp_upd_ready = 0; bus.ifu_redir_ready = 0;
    slot(0, 1, 1, 0, 0, 32'h200, 32'h300);
    slot(1, 1, 1, 0, 1, 32'h204, 32'h400);
    tick();
    slot(0, 1, 1, 1, 1, 32'h210, 32'h900);
    slot(1, 1, 1, 0, 1, 32'h214, 32'h990);
    tick();
    clear_in();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("s7_rst_redir", 72'(bus.redir_valid), 72'(0));
    chk("s7_rst_upd", 72'(bus.bp_upd_valid), 72'(0));
    tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 2; s++) begin
        logic [AW-1:0] pc;
        pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                          : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        slot(s, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, pc, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      end
      bus.exc_valid       = ($urandom_range(0, 11) == 0);
      bus.exc_target      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      bus.ifu_redir_ready = ($urandom_range(0, 3) != 0);
      bus.bp_upd_ready    = ($urandom_range(0, 1) == 1);
      rst_n               = ($urandom_range(0, 299) != 0);
      tick();
    end

    clear_in();
    rst_n = 1; bus.ifu_redir_ready = 1; bus.bp_upd_ready = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("end_redir_empty", 72'(redir_exp_q.size()), 72'(0));
    chk("end_upd_empty", 72'(upd_exp_q.size()), 72'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
